// File: rtl/arc4_pkg.sv
// Shared ARC4 types and constants: the PRGA state encoding, the byte type and
// the printable-ASCII window used by the optional plaintext check.
package arc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        LEN,
        RD_SI,
        RD_SJ,
        WR_SI,
        WR_SJ,
        RD_PAD,
        WR_PT,
        DONE
    } prga_state_e;

    localparam byte_t ASCII_LO = 8'h20;
    localparam byte_t ASCII_HI = 8'h7E;

    function automatic logic is_ascii(input byte_t b);
        return (b >= ASCII_LO) && (b <= ASCII_HI);
    endfunction

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation / decrypt stage: permutes S in place and writes
// the length-prefixed plaintext. Optional printable check via PRGA_ASCII_CHECK_EN.
module prga
    import arc4_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          rdy,
    output logic [AW-1:0] s_addr,
    input  logic [7:0]    s_rddata,
    output logic [7:0]    s_wrdata,
    output logic          s_wren,
    output logic [AW-1:0] ct_addr,
    input  logic [7:0]    ct_rddata,
    output logic [AW-1:0] pt_addr,
    output logic [7:0]    pt_wrdata,
    output logic          pt_wren
`ifdef PRGA_ASCII_CHECK_EN
    ,
    output logic          pt_ok
`endif
);

    prga_state_e state_q, state_d;
    byte_t       i_q, i_d;
    byte_t       j_q, j_d;
    byte_t       k_q, k_d;
    byte_t       len_q, len_d;
    byte_t       si_q, si_d;
    byte_t       sj_q, sj_d;
    byte_t       ct_byte_q, ct_byte_d;
    byte_t       jn;
    byte_t       pt_byte;
`ifdef PRGA_ASCII_CHECK_EN
    logic        pt_ok_q, pt_ok_d;

    assign pt_ok = pt_ok_q;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            len_q     <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            ct_byte_q <= '0;
`ifdef PRGA_ASCII_CHECK_EN
            pt_ok_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            len_q     <= len_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            ct_byte_q <= ct_byte_d;
`ifdef PRGA_ASCII_CHECK_EN
            pt_ok_q   <= pt_ok_d;
`endif
        end
    end

    // Next state, datapath updates and memory port drives.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        ct_byte_d = ct_byte_q;
`ifdef PRGA_ASCII_CHECK_EN
        pt_ok_d   = pt_ok_q;
`endif
        jn        = '0;
        pt_byte   = '0;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;

        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    state_d = LOAD;
`ifdef PRGA_ASCII_CHECK_EN
                    pt_ok_d = 1'b0;
`endif
                end
            end
            LOAD: begin
                ct_addr = '0;
                state_d = LEN;
            end
            LEN: begin
                len_d     = ct_rddata;
                pt_addr   = '0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                i_d       = 8'd1;
                j_d       = 8'd0;
                k_d       = 8'd1;
`ifdef PRGA_ASCII_CHECK_EN
                pt_ok_d   = 1'b1;
`endif
                state_d   = (ct_rddata == 8'd0) ? DONE : RD_SI;
            end
            RD_SI: begin
                s_addr  = AW'(i_q);
                ct_addr = AW'(k_q);
                state_d = RD_SJ;
            end
            RD_SJ: begin
                si_d      = s_rddata;
                ct_byte_d = ct_rddata;
                jn        = j_q + s_rddata;
                s_addr    = AW'(jn);
                j_d       = jn;
                state_d   = WR_SI;
            end
            WR_SI: begin
                // s_rddata is S[j]; latch it so a later i==j overlap never re-reads.
                sj_d     = s_rddata;
                s_addr   = AW'(i_q);
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = WR_SJ;
            end
            WR_SJ: begin
                s_addr   = AW'(j_q);
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = RD_PAD;
            end
            RD_PAD: begin
                s_addr  = AW'(byte_t'(si_q + sj_q));
                state_d = WR_PT;
            end
            WR_PT: begin
                pt_byte   = s_rddata ^ ct_byte_q;
                pt_addr   = AW'(k_q);
                pt_wrdata = pt_byte;
                pt_wren   = 1'b1;
`ifdef PRGA_ASCII_CHECK_EN
                if (!is_ascii(pt_byte)) pt_ok_d = 1'b0;
`endif
                if (k_q == len_q) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 8'd1;
                    i_d     = i_q + 8'd1;
                    state_d = RD_SI;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: behavioural ARC4 model against tb-owned S/ct/pt
// memories; pt_ok checks are compiled in with PRGA_ASCII_CHECK_EN.
module tb_prga;
    import arc4_pkg::*;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          rdy;
    logic [AW-1:0] s_addr;
    logic [7:0]    s_rddata;
    logic [7:0]    s_wrdata;
    logic          s_wren;
    logic [AW-1:0] ct_addr;
    logic [7:0]    ct_rddata;
    logic [AW-1:0] pt_addr;
    logic [7:0]    pt_wrdata;
    logic          pt_wren;
`ifdef PRGA_ASCII_CHECK_EN
    logic          pt_ok;
`endif

    always #5 clk = ~clk;

    prga #(.AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
`ifdef PRGA_ASCII_CHECK_EN
        ,
        .pt_ok     (pt_ok)
`endif
    );

    logic [7:0] s_mem    [256];
    logic [7:0] ct_mem   [256];
    logic [7:0] pt_mem   [256];
    logic [7:0] stage_s  [256];
    logic [7:0] stage_ct [256];
    logic [7:0] ref_s    [256];
    logic [7:0] ks_s     [256];
    logic [7:0] ks_out   [256];
    logic [7:0] ref_pt   [256];
    logic       ref_ok;
    logic       ld_req;
    int         s_wr_cnt  = 0;
    int         pt_wr_cnt = 0;
    int         n_vec = 0;
    int         n_err = 0;

    // Synchronous memories with one-cycle read latency; ld_req bulk-loads them.
    always @(posedge clk) begin
        if (ld_req) begin
            s_mem  <= stage_s;
            ct_mem <= stage_ct;
            for (int a = 0; a < 256; a++) pt_mem[a] <= 8'hA5;
        end else begin
            if (s_wren)  s_mem[s_addr]   <= s_wrdata;
            if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
        end
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (s_wren)  s_wr_cnt  <= s_wr_cnt + 1;
        if (pt_wren) pt_wr_cnt <= pt_wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Textbook ARC4 keystream from a copy of ref_s.
    task automatic keystream(input int len);
        int i, j;
        logic [7:0] t;
        ks_s = ref_s;
        i = 0;
        j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + int'(ks_s[i])) % 256;
            t = ks_s[i];
            ks_s[i] = ks_s[j];
            ks_s[j] = t;
            ks_out[n] = ks_s[(int'(ks_s[i]) + int'(ks_s[j])) % 256];
        end
    endtask

    task automatic model_run(input int len);
        keystream(len);
        ref_s     = ks_s;
        ref_pt[0] = 8'(len);
        ref_ok    = 1'b1;
        for (int n = 1; n <= len; n++) begin
            ref_pt[n] = stage_ct[n] ^ ks_out[n];
            if (ref_pt[n] < 8'h20 || ref_pt[n] > 8'h7E) ref_ok = 1'b0;
        end
    endtask

    task automatic load_mems();
        ref_s = stage_s;
        @(negedge clk);
        ld_req = 1'b1;
        @(negedge clk);
        ld_req = 1'b0;
    endtask

    task automatic rand_perm();
        int b;
        logic [7:0] t;
        for (int a = 0; a < 256; a++) stage_s[a] = 8'(a);
        for (int a = 255; a > 0; a--) begin
            b = int'($urandom_range(a, 0));
            t = stage_s[a];
            stage_s[a] = stage_s[b];
            stage_s[b] = t;
        end
    endtask

    task automatic ksa_perm();
        int j;
        logic [7:0] key [3];
        logic [7:0] t;
        for (int a = 0; a < 3; a++) key[a] = 8'($urandom);
        for (int a = 0; a < 256; a++) stage_s[a] = 8'(a);
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + int'(stage_s[a]) + int'(key[a % 3])) % 256;
            t = stage_s[a];
            stage_s[a] = stage_s[j];
            stage_s[j] = t;
        end
    endtask

    task automatic start_run(input string name);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        check({name, " accept"}, 32'(rdy), 32'd0);
    endtask

    // Counts edges after acceptance until rdy; optionally pulses en mid-run.
    task automatic wait_done(output int cyc, input int pulse_at);
        cyc = 0;
        while (rdy !== 1'b1 && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == pulse_at)          en = 1'b1;
            else if (cyc == pulse_at + 1) en = 1'b0;
        end
    endtask

    task automatic check_results(input string name, input int len, input int cyc,
                                 input int sw0, input int pw0);
        int diffs;
        check({name, " cycles"}, 32'(cyc), 32'(6 * len + 3));
        for (int n = 0; n <= len; n++)
            check($sformatf("%s pt[%0d]", name, n), 32'(pt_mem[n]), 32'(ref_pt[n]));
        if (len < 255)
            check({name, " pt untouched"}, 32'(pt_mem[len + 1]), 32'h0000_00A5);
        check({name, " pt writes"}, 32'(pt_wr_cnt - pw0), 32'(len + 1));
        check({name, " s writes"}, 32'(s_wr_cnt - sw0), 32'(2 * len));
        diffs = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== ref_s[a]) diffs++;
        check({name, " S diffs"}, 32'(diffs), 32'd0);
`ifdef PRGA_ASCII_CHECK_EN
        check({name, " pt_ok"}, 32'(pt_ok), 32'(ref_ok));
`endif
    endtask

    task automatic run_full(input string name, input int len);
        int cyc, sw0, pw0;
        model_run(len);
        sw0 = s_wr_cnt;
        pw0 = pt_wr_cnt;
        start_run(name);
        wait_done(cyc, -1);
        check_results(name, len, cyc, sw0, pw0);
    endtask

    initial begin
        int cyc, sw0, pw0, len, x, ptxt;
        en     = 1'b0;
        ld_req = 1'b0;
        rst_n  = 1'b0;
        for (int a = 0; a < 256; a++) begin
            stage_s[a]  = 8'(a);
            stage_ct[a] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst rdy", 32'(rdy), 32'd1);
        check("rst s_wren", 32'(s_wren), 32'd0);
        check("rst pt_wren", 32'(pt_wren), 32'd0);
        check("rst s_addr", 32'(s_addr), 32'd0);
        check("rst ct_addr", 32'(ct_addr), 32'd0);
        check("rst pt_addr", 32'(pt_addr), 32'd0);
        check("rst s_wrdata", 32'(s_wrdata), 32'd0);
        check("rst pt_wrdata", 32'(pt_wrdata), 32'd0);
`ifdef PRGA_ASCII_CHECK_EN
        check("rst pt_ok", 32'(pt_ok), 32'd0);
`endif
        rst_n = 1'b1;

        // Identity S, one zero byte: i==j==1 overlap.
        stage_ct[0] = 8'd1;
        load_mems();
        run_full("id1", 1);
        check("id1 pt1 const", 32'(pt_mem[1]), 32'h02);
        check("id1 s1 const", 32'(s_mem[1]), 32'h01);

        stage_ct[0] = 8'd2;
        load_mems();
        run_full("id2", 2);
        check("id2 pt2 const", 32'(pt_mem[2]), 32'h05);
        check("id2 s2 const", 32'(s_mem[2]), 32'h03);
        check("id2 s3 const", 32'(s_mem[3]), 32'h02);

        stage_ct[0] = 8'd0;
        load_mems();
        run_full("len0", 0);

        // en pulsed mid-run, then held across rdy to chain a second run.
        rand_perm();
        for (int a = 1; a < 256; a++) stage_ct[a] = 8'($urandom);
        stage_ct[0] = 8'd3;
        load_mems();
        model_run(3);
        sw0 = s_wr_cnt;
        pw0 = pt_wr_cnt;
        start_run("enmid");
        wait_done(cyc, 5);
        check_results("enmid", 3, cyc, sw0, pw0);
        en = 1'b1;
        model_run(3);
        sw0 = s_wr_cnt;
        pw0 = pt_wr_cnt;
        @(posedge clk);
        #1;
        en = 1'b0;
        check("rerun accept", 32'(rdy), 32'd0);
        wait_done(cyc, -1);
        check_results("rerun", 3, cyc, sw0, pw0);

        // Reset during WR_SJ of the first byte of a 5-byte message.
        rand_perm();
        for (int a = 1; a < 256; a++) stage_ct[a] = 8'($urandom);
        stage_ct[0] = 8'd5;
        load_mems();
        start_run("abort");
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("abort in wr_sj", 32'(s_wren), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort rdy", 32'(rdy), 32'd1);
        check("abort s_wren", 32'(s_wren), 32'd0);
        check("abort pt_wren", 32'(pt_wren), 32'd0);
        rst_n = 1'b1;
        load_mems();
        run_full("post_rst", 5);

        for (int t = 0; t < 4; t++) begin
            rand_perm();
            len = int'($urandom_range(20, 1));
            for (int a = 1; a < 256; a++) stage_ct[a] = 8'($urandom);
            stage_ct[0] = 8'(len);
            load_mems();
            run_full($sformatf("rand%0d", t), len);
        end

        // Key-scheduled S with a printable 255-byte message, then one bad byte.
        ksa_perm();
        ref_s = stage_s;
        keystream(255);
        stage_ct[0] = 8'd255;
        for (int n = 1; n <= 255; n++) begin
            ptxt = int'($urandom_range(126, 32));
            stage_ct[n] = 8'(ptxt) ^ ks_out[n];
        end
        load_mems();
        run_full("ascii", 255);
`ifdef PRGA_ASCII_CHECK_EN
        check("ascii ok const", 32'(pt_ok), 32'd1);
`endif
        x = int'($urandom_range(255, 1));
        stage_ct[x] = ks_out[x] ^ 8'h07;
        load_mems();
        run_full("ascii_bad", 255);
        check("ascii_bad byte", 32'(pt_mem[x]), 32'h07);
`ifdef PRGA_ASCII_CHECK_EN
        check("ascii_bad ok const", 32'(pt_ok), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
